// File: rtl/simon_pad_renderer.sv
// Simon pad renderer: N_PADS coloured pads over white, per-pad level fixed per frame, fading frame by frame.
// Latency 2 cycles pixel_x/pixel_y -> RGB; no backpressure, free-running pixel stream.
module simon_pad_renderer #(
  parameter int                  N_PADS      = 4,
  parameter int                  H_ACTIVE    = 640,
  parameter int                  V_ACTIVE    = 480,
  parameter int                  PAD_X0      = 116,
  parameter int                  PAD_PITCH   = 116,
  parameter int                  PAD_W       = 59,
  parameter int                  PAD_Y0      = 192,
  parameter int                  PAD_H       = 97,
  parameter logic [3:0]          DIM_LEVEL   = 4'd6,
  parameter int                  FADE_FRAMES = 4,
  parameter logic [3*N_PADS-1:0] PAD_RGB     = 12'b100_110_010_001
) (
  input  logic              clk_d,
  input  logic              rst_n,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              frame_start,
  input  logic [N_PADS-1:0] led,
  input  logic [2:0]        state,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue
);

  localparam int CW = $clog2(FADE_FRAMES) + 1;
  localparam int IW = (N_PADS > 1) ? $clog2(N_PADS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FADE_FRAMES - 1);

  logic [3:0]    level [N_PADS];
  logic [CW-1:0] cnt   [N_PADS];

  logic non_game;
  assign non_game = (state == 3'b000) || (state == 3'b111);

  // Levels only move on frame_start so a frame never shows two intensities for one pad.
  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PADS; i++) begin
        level[i] <= DIM_LEVEL;
        cnt[i]   <= '0;
      end
    end else if (frame_start) begin
      for (int i = 0; i < N_PADS; i++) begin
        if (non_game) begin
          level[i] <= DIM_LEVEL;
          cnt[i]   <= '0;
        end else if (led[i]) begin
          level[i] <= 4'hF;
          cnt[i]   <= '0;
        end else if (level[i] > DIM_LEVEL) begin
          if (cnt[i] == CNT_LAST) begin
            level[i] <= level[i] - 4'd1;
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  function automatic logic [10:0] pad_left(input int i);
    return 11'(PAD_X0 + i * PAD_PITCH);
  endfunction

  logic [10:0]   x11, y11;
  logic          active_c, hit_c;
  logic [IW-1:0] idx_c;

  assign x11      = {1'b0, pixel_x};
  assign y11      = {1'b0, pixel_y};
  assign active_c = (x11 < 11'(H_ACTIVE)) && (y11 < 11'(V_ACTIVE));

  // Scan from the top index down so the lowest overlapping pad wins.
  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
    for (int i = N_PADS - 1; i >= 0; i--) begin
      if (x11 >= pad_left(i) && x11 <= pad_left(i) + 11'(PAD_W - 1) &&
          y11 >= 11'(PAD_Y0) && y11 <= 11'(PAD_Y0 + PAD_H - 1)) begin
        hit_c = 1'b1;
        idx_c = IW'(i);
      end
    end
  end

  logic          act_q, game_q, hit_q;
  logic [IW-1:0] idx_q;

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      act_q  <= 1'b0;
      game_q <= 1'b0;
      hit_q  <= 1'b0;
      idx_q  <= '0;
    end else begin
      act_q  <= active_c;
      game_q <= !non_game;
      hit_q  <= hit_c;
      idx_q  <= idx_c;
    end
  end

  logic [2:0] sel_mask;
  logic [3:0] sel_lvl;

  always_comb begin
    sel_mask = 3'b000;
    sel_lvl  = 4'h0;
    for (int i = 0; i < N_PADS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_mask = PAD_RGB[3*i +: 3];
        sel_lvl  = level[i];
      end
    end
  end

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      red   <= 4'h0;
      green <= 4'h0;
      blue  <= 4'h0;
    end else if (!act_q) begin
      red   <= 4'h0;
      green <= 4'h0;
      blue  <= 4'h0;
    end else if (game_q && hit_q) begin
      red   <= sel_mask[2] ? sel_lvl : 4'h0;
      green <= sel_mask[1] ? sel_lvl : 4'h0;
      blue  <= sel_mask[0] ? sel_lvl : 4'h0;
    end else begin
      red   <= 4'hF;
      green <= 4'hF;
      blue  <= 4'hF;
    end
  end

endmodule

// File: tb/tb_simon_pad_renderer.sv
// Directed bench for simon_pad_renderer: a static vector table plus sequences for fading, reset and frame timing.
module tb_simon_pad_renderer;

  logic       clk_d = 1'b0;
  logic       rst_n;
  logic [9:0] pixel_x, pixel_y;
  logic       frame_start;
  logic [3:0] led;
  logic [5:0] led6;
  logic [2:0] state;
  logic [3:0] red, green, blue;
  logic [3:0] red6, green6, blue6;
  logic [11:0] rgb, rgb6;

  int checks = 0;
  int errors = 0;

  always #5 clk_d = ~clk_d;

  assign rgb  = {red, green, blue};
  assign rgb6 = {red6, green6, blue6};

  simon_pad_renderer dut (
    .clk_d(clk_d), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start), .led(led), .state(state),
    .red(red), .green(green), .blue(blue)
  );

  simon_pad_renderer #(
    .N_PADS(6), .PAD_X0(20), .PAD_PITCH(100),
    .PAD_RGB(18'b011_101_100_110_010_001)
  ) dut6 (
    .clk_d(clk_d), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start), .led(led6), .state(state),
    .red(red6), .green(green6), .blue(blue6)
  );

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  st;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [18];

  task automatic tick();
    @(posedge clk_d);
    #1;
  endtask

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s rgb=%h expected %h", name, got, exp);
    end
  endtask

  task automatic show(input logic [9:0] x, input logic [9:0] y);
    pixel_x = x;
    pixel_y = y;
    tick();
    tick();
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  initial begin
    // All levels at DIM (6), state 001 unless noted.
    vecs[0]  = '{10'd120,  10'd200,  3'b001, 12'h006};
    vecs[1]  = '{10'd240,  10'd250,  3'b001, 12'h060};
    vecs[2]  = '{10'd350,  10'd200,  3'b001, 12'h660};
    vecs[3]  = '{10'd470,  10'd288,  3'b001, 12'h600};
    vecs[4]  = '{10'd300,  10'd250,  3'b001, 12'hFFF};
    vecs[5]  = '{10'd116,  10'd191,  3'b001, 12'hFFF};
    vecs[6]  = '{10'd116,  10'd192,  3'b001, 12'h006};
    vecs[7]  = '{10'd174,  10'd288,  3'b001, 12'h006};
    vecs[8]  = '{10'd175,  10'd250,  3'b001, 12'hFFF};
    vecs[9]  = '{10'd120,  10'd289,  3'b001, 12'hFFF};
    vecs[10] = '{10'd650,  10'd200,  3'b001, 12'h000};
    vecs[11] = '{10'd120,  10'd490,  3'b001, 12'h000};
    vecs[12] = '{10'd639,  10'd479,  3'b001, 12'hFFF};
    vecs[13] = '{10'd1023, 10'd1023, 3'b001, 12'h000};
    vecs[14] = '{10'd120,  10'd200,  3'b000, 12'hFFF};
    vecs[15] = '{10'd470,  10'd250,  3'b111, 12'hFFF};
    vecs[16] = '{10'd650,  10'd250,  3'b111, 12'h000};
    vecs[17] = '{10'd522,  10'd250,  3'b101, 12'h600};

    rst_n = 1'b0; frame_start = 1'b0; led = '0; led6 = '0;
    state = 3'b001; pixel_x = '0; pixel_y = '0;
    #2;
    check("reset_rgb", rgb, 12'h000);
    check("reset_rgb6", rgb6, 12'h000);
    tick(); tick(); tick();
    rst_n = 1'b1;

    // Latency: new pixel reaches RGB on the second edge, not the first.
    show(10'd300, 10'd250);
    check("lat_pre", rgb, 12'hFFF);
    pixel_x = 10'd120; pixel_y = 10'd200;
    tick();
    check("lat_1cyc", rgb, 12'hFFF);
    tick();
    check("lat_2cyc", rgb, 12'h006);

    foreach (vecs[i]) begin
      state = vecs[i].st;
      show(vecs[i].x, vecs[i].y);
      check($sformatf("vec%0d", i), rgb, vecs[i].exp);
    end
    state = 3'b001;

    // Lit pad 1.
    led = 4'b0010; frame(); led = '0;
    show(10'd240, 10'd250);
    check("lit_green", rgb, 12'h0F0);
    show(10'd300, 10'd250);
    check("lit_gap", rgb, 12'hFFF);

    // Mid-run asynchronous reset.
    show(10'd240, 10'd250);
    #3 rst_n = 1'b0;
    #1 check("midrst_rgb", rgb, 12'h000);
    tick(); tick();
    rst_n = 1'b1;
    show(10'd240, 10'd250);
    check("midrst_level", rgb, 12'h060);

    // led pulse between frame_starts is never latched.
    frame();
    led = 4'b0001;
    repeat (10) tick();
    led = '0;
    frame();
    show(10'd120, 10'd250);
    check("midframe_led", rgb, 12'h006);

    // Fade of pad 3: 15 for four frames, then one step per four frames, floor 6.
    led = 4'b1000; frame(); led = '0;
    show(10'd470, 10'd250);
    check("fade_j0", rgb, 12'hF00);
    for (int j = 1; j <= 40; j++) begin
      int e;
      e = 15 - j / 4;
      if (e < 6) e = 6;
      frame();
      show(10'd470, 10'd250);
      check($sformatf("fade_j%0d", j), rgb, {4'(e), 8'h00});
    end

    // Re-light pad 0 while fading at level 9 (cnt mid-count): restart at 15 with cnt cleared.
    led = 4'b0001; frame(); led = '0;
    for (int j = 1; j <= 25; j++) frame();
    show(10'd120, 10'd250);
    check("relight_pre9", rgb, 12'h009);
    led = 4'b0001; frame(); led = '0;
    show(10'd120, 10'd250);
    check("relight_15", rgb, 12'h00F);
    for (int j = 1; j <= 4; j++) begin
      frame();
      show(10'd120, 10'd250);
      check($sformatf("relight_j%0d", j), rgb, (j < 4) ? 12'h00F : 12'h00E);
    end

    // Non-game screen: white pads, level cleared only at next frame_start.
    led = 4'b0100; frame(); led = '0;
    state = 3'b111;
    show(10'd350, 10'd250);
    check("screen_white", rgb, 12'hFFF);
    state = 3'b001;
    show(10'd350, 10'd250);
    check("screen_noclear", rgb, 12'hFF0);
    state = 3'b111;
    frame();
    state = 3'b001;
    show(10'd350, 10'd250);
    check("screen_cleared", rgb, 12'h660);

    // Clear beats led when both land on the same frame_start.
    led = 4'b1111; frame();
    show(10'd350, 10'd250);
    check("all_lit", rgb, 12'hFF0);
    state = 3'b000; frame_start = 1'b1;
    tick();
    frame_start = 1'b0; led = '0; state = 3'b001;
    show(10'd120, 10'd250); check("simul_p0", rgb, 12'h006);
    show(10'd240, 10'd250); check("simul_p1", rgb, 12'h060);
    show(10'd350, 10'd250); check("simul_p2", rgb, 12'h660);
    show(10'd470, 10'd250); check("simul_p3", rgb, 12'h600);

    // Six-pad variant: pad 5 is cyan, pad 4 magenta.
    led6 = 6'b100000; frame(); led6 = '0;
    show(10'd520, 10'd250);
    check("n6_pad5_lit", rgb6, 12'h0FF);
    show(10'd420, 10'd250);
    check("n6_pad4_dim", rgb6, 12'h606);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_pad_renderer.md
Name: simon_pad_renderer

Overview:
- Parametrised successor to the game-screen pad renderer in the VGA path.
- Draws N_PADS coloured Simon pads on a white background, with per-pad intensity that is fixed within a frame and fades out frame by frame.
- Sits between the VGA sync counter (pixel_x, pixel_y, frame_start) and the RGB output pins.
- Driven by the game FSM state and the LED lines.

Parameters:
- N_PADS, 4, number of pads (1..8).
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- PAD_X0, 116, left x of pad 0.
- PAD_PITCH, 116, x distance between left edges of adjacent pads.
- PAD_W, 59, pad width in pixels.
- PAD_Y0, 192, top y of all pads.
- PAD_H, 97, pad height in pixels.
- DIM_LEVEL, 6, idle intensity (4-bit, < 15).
- FADE_FRAMES, 4, frames per one-step intensity decrement (>= 1).
- PAD_RGB, 12'b100_110_010_001, 3 bits per pad {r,g,b} colour-enable mask. Pad 0 is in the LSBs. Default pads are blue, green, yellow, red.

Ports:
- clk_d  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- pixel_x  in  10  current pixel x.
- pixel_y  in  10  current pixel y.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- led  in  N_PADS  pad lit requests, sampled only on frame_start.
- state  in  3  game FSM state; 3'b000 and 3'b111 are non-game screens.
- red  out  4  red intensity.
- green  out  4  green intensity.
- blue  out  4  blue intensity.

Behaviour:
- Reset (rst_n low, asynchronous):
  - red, green, blue = 0.
  - All pipeline registers = 0.
  - level[i] = DIM_LEVEL.
  - cnt[i] = 0.
- Per-pad state:
  - level[i]: 4 bits.
  - cnt[i]: clog2(FADE_FRAMES)+1 bits.
  - Both update only in cycles where frame_start=1, so the image is tear-free.
- Level update, evaluated per pad in priority order on each frame_start:
  1. state is 000 or 111 -> level = DIM_LEVEL, cnt = 0.
  2. led[i]=1 -> level = 15, cnt = 0.
  3. level > DIM_LEVEL -> if cnt == FADE_FRAMES-1, then level -= 1 and cnt = 0; otherwise cnt += 1.
  4. Otherwise -> hold level and cnt.
- Level bounds:
  - level never goes below DIM_LEVEL and never exceeds 15.
  - A state change to 000/111 in a non-frame_start cycle has no effect until the next frame_start.
- Mid-frame led edges are ignored. A led pulse that never overlaps a frame_start is not shown.
- Pipeline, fixed 2-cycle latency from pixel_x/pixel_y to RGB:
  - Stage 1 registers:
    - active = (pixel_x < H_ACTIVE) && (pixel_y < V_ACTIVE).
    - game = (state != 000 && state != 111).
    - hit = any pad hit.
    - idx = lowest pad index i satisfying PAD_X0+i*PAD_PITCH <= x <= PAD_X0+i*PAD_PITCH+PAD_W-1 and PAD_Y0 <= y <= PAD_Y0+PAD_H-1.
  - Stage 2 registers RGB:
    - !active -> 0,0,0.
    - active && game && hit -> each channel = PAD_RGB bit ? level[idx] : 0.
    - Otherwise -> F,F,F.
  - Stage 2 uses the level value present in that cycle.
  - Pad bounds are computed with 11-bit arithmetic, so no wrap at 1023. Pads extending past H_ACTIVE are clipped to black by !active.
- Overlapping pads: the lowest index wins.
- Non-game screens (000/111) render white active area and black blanking. The text overlays are a separate block.

Test Plan:
- Reset and latency:
  - Assert rst_n=0 mid-run -> RGB=000 immediately and all levels=6.
  - Release; drive state=001, x=120, y=200 -> exactly 2 cycles later RGB=0,0,6.
- Lit pad:
  - led=4'b0010 held across a frame_start, then x=240, y=250 -> green=F, red=blue=0.
  - x=300 (gap between pads) -> RGB=F,F,F.
- Fade timing, FADE_FRAMES=4:
  - led[3] high for one frame_start k, then low.
  - level[3] stays 15 through frame_starts k+1..k+3 and drops to 14 at k+4.
  - level[3] reaches 6 at k+36 and stays 6 thereafter.
  - Red pad pixel reads red=level, green=blue=0.
- Mid-frame led:
  - led[0] pulses 10 cycles between frame_starts -> pad 0 stays at 6.
  - Re-assert led[0] during fading at level 9 -> level 15 at that frame_start, and cnt restarts.
- Screen and blanking:
  - state=111 with level[2]=15 -> pad area renders F,F,F.
  - Next frame_start -> level[2]=6.
  - x=650 or y=490 in any state -> RGB=000.
- Simultaneous events and parameters:
  - frame_start, led=4'b1111 and state=000 in the same cycle -> all levels=6, because clearing has priority.
  - Rerun the lit-pad test with N_PADS=6 and PAD_RGB extended -> pad 5 at x=PAD_X0+5*PAD_PITCH lights per its mask.
